// File: rtl/ngc_counter_sched_pkg.sv
// rtl/ngc_counter_sched_pkg.sv - shared types and helpers for the counter scheduler
package ngc_counter_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Channel-id width that never collapses to zero bits.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ngc_counter_sched_rr_arbiter.sv
// rtl/ngc_counter_sched_rr_arbiter.sv - round-robin arbiter, combinational grant, registered pointer
module ngc_rr_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_req,
  input  logic            i_en,
  output logic [N_CH-1:0] o_gnt,
  output logic [ID_W-1:0] o_gnt_id
);

  logic [ID_W-1:0] r_ptr;
  logic            w_found;

  always_comb begin
    int w_idx;
    w_found  = 1'b0;
    o_gnt    = '0;
    o_gnt_id = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N_CH) w_idx = w_idx - N_CH;
      if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        o_gnt_id = w_idx[ID_W-1:0];
      end
    end
    if (w_found) o_gnt[o_gnt_id] = 1'b1;
  end

  // Pointer only advances on a taken grant, so an unused cycle keeps fairness intact.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (int'(o_gnt_id) == N_CH - 1) ? '0 : o_gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/ngc_counter_sched.sv
// rtl/ngc_counter_sched.sv - time-shares one external one-shot counter among N_CH delay requesters
module ngc_counter_sched
  import ngc_counter_sched_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 16,
  localparam int ID_W = id_w(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_CH-1:0]   i_req,
  input  logic [N_CH*W-1:0] i_dur,
  input  logic [N_CH-1:0]   i_cancel,
  output logic [N_CH-1:0]   o_done,
  output logic [N_CH-1:0]   o_pending,
  output logic              o_busy,
  output logic [ID_W-1:0]   o_active_id,
  output logic              o_cnt_rst,
  output logic              o_cnt_load,
  output logic              o_cnt_enb,
  output logic              o_cnt_dir,
  output logic              o_cnt_one_shot,
  output logic [W-1:0]      o_cnt_from_value,
  output logic [W-1:0]      o_cnt_step_value,
  output logic [W-1:0]      o_cnt_to_value,
  input  logic              i_cnt_hit
);

  state_t          r_state, w_next;
  logic [N_CH-1:0] r_pending, r_done, w_gnt;
  logic [W-1:0]    r_dur_q [N_CH];
  logic [W-1:0]    r_to_value;
  logic [ID_W-1:0] r_active_id, w_gnt_id;
  logic            w_take, w_cancel_act, w_any;

  assign w_any        = |r_pending;
  assign w_cancel_act = i_cancel[r_active_id] && (r_state == LOAD || r_state == RUN);

  ngc_rr_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (r_pending),
    .i_en     (w_take),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_next = LOAD;
        w_take = 1'b1;
      end
      LOAD: w_next = w_cancel_act ? IDLE : RUN;
      RUN: begin
        if (w_cancel_act)   w_next = IDLE;
        else if (i_cnt_hit) w_next = DONE;
      end
      DONE: begin
        // Re-grant straight from DONE so queued channels run back-to-back.
        if (w_any) begin
          w_next = LOAD;
          w_take = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_active_id <= '0;
      r_to_value  <= '0;
      r_done      <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= '0;
      if (w_take) r_active_id <= w_gnt_id;
      if (r_state == LOAD) r_to_value <= r_dur_q[r_active_id];
      if (r_state == RUN && w_next == DONE) r_done[r_active_id] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      for (int i = 0; i < N_CH; i++) r_dur_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (i_cancel[i] || (w_take && w_gnt[i])) begin
          r_pending[i] <= 1'b0;
        end else if (i_req[i] && !r_pending[i]) begin
          r_pending[i] <= 1'b1;
          r_dur_q[i]   <= i_dur[i*W +: W];
        end
      end
    end
  end

  // Target is presented live during LOAD and then frozen for the counter's registered compare.
  assign o_cnt_to_value   = i_rst ? '0 : ((r_state == LOAD) ? r_dur_q[r_active_id] : r_to_value);
  assign o_cnt_rst        = i_rst || (r_state == LOAD);
  assign o_cnt_enb        = !i_rst && (r_state == RUN);
  assign o_cnt_load       = 1'b0;
  assign o_cnt_dir        = 1'b0;
  assign o_cnt_one_shot   = 1'b1;
  assign o_cnt_from_value = '0;
  assign o_cnt_step_value = W'(1);
  assign o_done           = r_done;
  assign o_pending        = r_pending;
  assign o_busy           = (r_state != IDLE);
  assign o_active_id      = r_active_id;

endmodule

// File: tb/tb_ngc_counter_sched.sv
// tb/tb_ngc_counter_sched.sv - self-checking bench for ngc_counter_sched with behavioural one-shot counter
module tb_ngc_counter_sched;
  localparam int N_CH = 4;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   req, cancel, done, pending;
  logic [N_CH*W-1:0] dur;
  logic              busy;
  logic [1:0]        active_id;
  logic              cnt_rst, cnt_load, cnt_enb, cnt_dir, cnt_one_shot, cnt_hit;
  logic [W-1:0]      cnt_from_value, cnt_step_value, cnt_to_value, cnt_count;

  always #5 clk = ~clk;

  ngc_counter_sched #(.N_CH(N_CH), .W(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_dur(dur), .i_cancel(cancel),
    .o_done(done), .o_pending(pending), .o_busy(busy), .o_active_id(active_id),
    .o_cnt_rst(cnt_rst), .o_cnt_load(cnt_load), .o_cnt_enb(cnt_enb), .o_cnt_dir(cnt_dir),
    .o_cnt_one_shot(cnt_one_shot), .o_cnt_from_value(cnt_from_value),
    .o_cnt_step_value(cnt_step_value), .o_cnt_to_value(cnt_to_value), .i_cnt_hit(cnt_hit)
  );

  // One-shot up counter with registered target compare.
  always @(posedge clk) begin
    if (cnt_rst) begin
      cnt_count <= cnt_from_value;
      cnt_hit   <= 1'b0;
    end else begin
      if (cnt_load) cnt_count <= cnt_from_value;
      else if (cnt_enb && cnt_count != cnt_to_value) cnt_count <= cnt_count + cnt_step_value;
      cnt_hit <= cnt_enb && (cnt_count == cnt_to_value);
    end
  end

  int cyc = 0, nchk = 0, nerr = 0, max_cnt = 0, busy_cnt = 0, m_ptr = 0;
  int done_ch[$], done_cyc[$];
  int jd[N_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N_CH; i++) if (done[i] === 1'b1) begin
      done_ch.push_back(i);
      done_cyc.push_back(cyc);
    end
    if (busy === 1'b1) busy_cnt++;
    if (int'(cnt_count) > max_cnt) max_cnt = int'(cnt_count);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; cancel = '0;
    tick(); tick();
    rst = 1'b0; m_ptr = 0;
    tick();
  endtask

  task automatic clear_log();
    done_ch.delete(); done_cyc.delete(); busy_cnt = 0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int b = 0;
    while (done_ch.size() < n && b < budget) begin
      tick(); b++;
    end
    chk({tag, "_ndone"}, done_ch.size(), n);
  endtask

  // Simultaneous post from idle: expected order is RR from the model pointer, each job
  // finishing dur+3 edges after its grant, the next grant one edge after a done.
  task automatic batch(input logic [N_CH-1:0] mask, input string tag);
    int r, g, g0, d, last, ch;
    int exp_ch[$], exp_cyc[$];
    clear_log();
    for (int i = 0; i < N_CH; i++) dur[i*W +: W] = W'(jd[i]);
    req = mask;
    tick();
    req = '0;
    r = cyc;
    chk({tag, "_pending"}, pending, mask);
    g = r + 1; g0 = g; d = g; last = m_ptr;
    for (int k = 0; k < N_CH; k++) begin
      ch = (m_ptr + k) % N_CH;
      if (mask[ch]) begin
        d = g + jd[ch] + 3;
        exp_ch.push_back(ch); exp_cyc.push_back(d);
        last = ch; g = d + 1;
      end
    end
    m_ptr = (last + 1) % N_CH;
    wait_dones(exp_ch.size(), 400, tag);
    for (int j = 0; j < exp_ch.size(); j++) begin
      chk({tag, "_order"}, (j < done_ch.size()) ? done_ch[j] : -1, exp_ch[j]);
      chk({tag, "_time"}, (j < done_cyc.size()) ? done_cyc[j] : -1, exp_cyc[j]);
    end
    chk({tag, "_busy_cycles"}, busy_cnt, d - g0 + 1);
    tick();
    chk({tag, "_idle_after"}, busy, 1'b0);
    chk({tag, "_pending_after"}, pending, '0);
  endtask

  initial begin
    int r1, g, b;
    rst = 1'b1; req = '0; cancel = '0; dur = '0;
    tick(); tick();
    chk("rst_cnt_rst", cnt_rst, 1'b1);
    chk("rst_cnt_enb", cnt_enb, 1'b0);
    chk("rst_to_value", cnt_to_value, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pending", pending, 0);
    chk("rst_done", done, 0);
    chk("tie_one_shot", cnt_one_shot, 1'b1);
    chk("tie_step", cnt_step_value, 1);
    rst = 1'b0; tick();

    jd[0] = 5;
    batch(4'b0001, "single");

    do_reset();
    jd[2] = 0; max_cnt = 0;
    batch(4'b0100, "dur0");
    chk("dur0_max_count", max_cnt, 0);

    do_reset();
    for (int i = 0; i < N_CH; i++) jd[i] = 2;
    batch(4'b1111, "rr1");
    batch(4'b1111, "rr2");

    do_reset();
    clear_log();
    for (int i = 0; i < N_CH; i++) dur[i*W +: W] = W'(1);
    req = 4'b1001; tick();
    req = 4'b0001;
    wait_dones(2, 100, "fair");
    chk("fair_first", (done_ch.size() > 0) ? done_ch[0] : -1, 0);
    chk("fair_second", (done_ch.size() > 1) ? done_ch[1] : -1, 3);
    req = '0;
    b = 0;
    while ((busy !== 1'b0 || pending !== '0) && b < 60) begin tick(); b++; end
    chk("fair_drain", busy, 1'b0);

    do_reset();
    clear_log();
    dur[1*W +: W] = W'(100); req = 4'b0010; tick();
    dur[2*W +: W] = W'(4);   req = 4'b0100; tick();
    req = '0;
    b = 0;
    while (cnt_count !== W'(40) && b < 300) begin tick(); b++; end
    chk("cancel_reach40", cnt_count, 40);
    cancel = 4'b0010; tick();
    cancel = '0;
    chk("cancel_busy", busy, 1'b0);
    chk("cancel_pending", pending, 4'b0100);
    chk("cancel_enb", cnt_enb, 1'b0);
    tick(); g = cyc;
    chk("cancel_next_busy", busy, 1'b1);
    chk("cancel_next_id", active_id, 2);
    chk("cancel_next_load", cnt_rst, 1'b1);
    wait_dones(1, 100, "cancel");
    chk("cancel_done_ch", (done_ch.size() > 0) ? done_ch[0] : -1, 2);
    chk("cancel_done_time", (done_cyc.size() > 0) ? done_cyc[0] : -1, g + 7);

    tick();
    dur[3*W +: W] = W'(9); req = 4'b1000; cancel = 4'b1000; tick();
    req = '0; cancel = '0;
    chk("collide_pending", pending, 0);
    chk("collide_busy", busy, 1'b0);

    clear_log();
    dur[1*W +: W] = W'(20); req = 4'b0010; tick();
    r1 = cyc; req = '0; tick();
    dur[0*W +: W] = W'(7);  req = 4'b0001; tick();
    dur[0*W +: W] = W'(30); tick();
    req = '0;
    chk("dup_pending", pending, 4'b0001);
    wait_dones(2, 200, "dup");
    chk("dup_first_time", (done_cyc.size() > 0) ? done_cyc[0] : -1, r1 + 1 + 20 + 3);
    chk("dup_second_ch", (done_ch.size() > 1) ? done_ch[1] : -1, 0);
    chk("dup_second_gap", (done_cyc.size() > 1) ? done_cyc[1] - done_cyc[0] : -1, 1 + 7 + 3);

    tick();
    dur[2*W +: W] = W'(50); req = 4'b0100; tick();
    req = '0;
    b = 0;
    while (cnt_count !== W'(10) && b < 100) begin tick(); b++; end
    chk("rstrun_reach10", cnt_count, 10);
    dur[1*W +: W] = W'(3); req = 4'b0010; tick();
    req = '0;
    rst = 1'b1; tick();
    chk("rstrun_busy", busy, 1'b0);
    chk("rstrun_pending", pending, 0);
    chk("rstrun_done", done, 0);
    chk("rstrun_cnt_rst", cnt_rst, 1'b1);
    chk("rstrun_cnt_enb", cnt_enb, 1'b0);
    chk("rstrun_to_value", cnt_to_value, 0);
    chk("rstrun_active_id", active_id, 0);
    rst = 1'b0; tick(); tick();
    chk("rstrun_stays_idle", busy, 1'b0);

    do_reset();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_CH; i++) jd[i] = $urandom_range(0, 12);
      batch(4'($urandom_range(1, 15)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
